// File: rtl/acc_rmw_ctrl_pkg.sv
// Shared definitions for the accumulator read-modify-write controller:
// default geometry, saturation limits and the controller state encoding.
package acc_pkg;

    localparam int ACC_AW    = 13;
    localparam int ACC_DW    = 32;
    localparam int ACC_DEPTH = 2048;

    localparam logic [ACC_DW-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [ACC_DW-1:0] SAT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        ADD  = 3'd2,
        WR   = 3'd3,
        HRD  = 3'd4,
        HCAP = 3'd5,
        CLR  = 3'd6
    } state_t;

endpackage

// File: rtl/acc_rmw_ctrl_if.sv
// Bundle of the partial-sum stream, host readout, clear request and the
// single-port accumulator SRAM signals seen by acc_rmw_ctrl.
interface acc_rmw_ctrl_if
    import acc_pkg::*;
#(
    parameter int AW = ACC_AW,
    parameter int DW = ACC_DW
);

    logic          clear_i;
    logic          clr_done_o;

    logic          in_valid_i;
    logic          in_ready_o;
    logic [AW-1:0] in_addr_i;
    logic [DW-1:0] in_data_i;
    logic          in_first_i;

    logic          rd_req_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_ack_o;
    logic          rd_valid_o;
    logic [DW-1:0] rd_data_o;

    logic          busy_o;

    logic          ram_en_o;
    logic          ram_we_o;
    logic [AW-1:0] ram_w_addr_o;
    logic [AW-1:0] ram_r_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i;

    // Controller side
    modport slave (
        input  clear_i,
        input  in_valid_i,
        input  in_addr_i,
        input  in_data_i,
        input  in_first_i,
        input  rd_req_i,
        input  rd_addr_i,
        input  ram_rdata_i,
        output clr_done_o,
        output in_ready_o,
        output rd_ack_o,
        output rd_valid_o,
        output rd_data_o,
        output busy_o,
        output ram_en_o,
        output ram_we_o,
        output ram_w_addr_o,
        output ram_r_addr_o,
        output ram_wdata_o
    );

    // Requester / SRAM side
    modport master (
        output clear_i,
        output in_valid_i,
        output in_addr_i,
        output in_data_i,
        output in_first_i,
        output rd_req_i,
        output rd_addr_i,
        output ram_rdata_i,
        input  clr_done_o,
        input  in_ready_o,
        input  rd_ack_o,
        input  rd_valid_o,
        input  rd_data_o,
        input  busy_o,
        input  ram_en_o,
        input  ram_we_o,
        input  ram_w_addr_o,
        input  ram_r_addr_o,
        input  ram_wdata_o
    );

endinterface

// File: rtl/acc_rmw_ctrl_sat_add.sv
// Combinational DW-bit signed adder; SATURATE=1 clamps to the signed range,
// SATURATE=0 wraps modulo 2^DW.
module acc_sat_add
    import acc_pkg::*;
#(
    parameter int DW       = ACC_DW,
    parameter int SATURATE = 0
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] sum
);

    logic [DW-1:0] raw_sum;

    assign raw_sum = a + b;

    generate
        if (SATURATE != 0) begin : g_sat
            logic ovf_pos;
            logic ovf_neg;

            // Overflow only when both operands share a sign the result lacks
            assign ovf_pos = ~a[DW-1] & ~b[DW-1] &  raw_sum[DW-1];
            assign ovf_neg =  a[DW-1] &  b[DW-1] & ~raw_sum[DW-1];

            always_comb begin
                sum = raw_sum;
                if (ovf_pos) begin
                    sum = {1'b0, {(DW-1){1'b1}}};
                end else if (ovf_neg) begin
                    sum = {1'b1, {(DW-1){1'b0}}};
                end
            end
        end else begin : g_wrap
            assign sum = raw_sum;
        end
    endgenerate

endmodule

// File: rtl/acc_rmw_ctrl.sv
// Serial read-modify-write controller in front of the accumulator SRAM:
// accumulates or overwrites partial sums, serves host reads and zero-fills.
module acc_rmw_ctrl
    import acc_pkg::*;
#(
    parameter int AW       = ACC_AW,
    parameter int DW       = ACC_DW,
    parameter int DEPTH    = ACC_DEPTH,
    parameter int SATURATE = 0
) (
    input  logic          clk,
    input  logic          rst,
    acc_rmw_ctrl_if.slave bus
);

    localparam int CW = $clog2(DEPTH);

    state_t          state_reg, state_next;
    logic [AW-3:0]   word_reg, word_next;
    logic [DW-1:0]   data_reg, data_next;
    logic            first_reg, first_next;
    logic [DW-1:0]   sum_reg, sum_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [DW-1:0]   rd_data_reg, rd_data_next;
    logic            rd_valid_reg, rd_valid_next;
    logic            clr_done_reg, clr_done_next;
    logic            busy_reg;

    logic            in_ready;
    logic            rd_ack;
    logic            ram_en;
    logic            ram_we;
    logic [AW-1:0]   op_addr;
    logic [AW-1:0]   clr_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   add_result;

    // Byte-lane bits of the incoming addresses carry no meaning for word access
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{bus.in_addr_i[1:0], bus.rd_addr_i[1:0]};

    acc_sat_add #(
        .DW       (DW),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .a   (bus.ram_rdata_i),
        .b   (data_reg),
        .sum (add_result)
    );

    always_comb begin
        clr_addr              = '0;
        clr_addr[CW+1:0]      = {cnt_reg, 2'b00};
    end

    always_comb begin
        state_next    = state_reg;
        word_next     = word_reg;
        data_next     = data_reg;
        first_next    = first_reg;
        sum_next      = sum_reg;
        cnt_next      = cnt_reg;
        rd_data_next  = rd_data_reg;
        rd_valid_next = 1'b0;
        clr_done_next = 1'b0;

        in_ready      = 1'b0;
        rd_ack        = 1'b0;
        ram_en        = 1'b0;
        ram_we        = 1'b1;
        op_addr       = '0;
        ram_wdata     = '0;

        case (state_reg)
            IDLE: begin
                in_ready = ~bus.clear_i & ~bus.rd_req_i;
                rd_ack   = ~bus.clear_i &  bus.rd_req_i;
                if (bus.clear_i) begin
                    cnt_next   = '0;
                    state_next = CLR;
                end else if (bus.rd_req_i) begin
                    word_next  = bus.rd_addr_i[AW-1:2];
                    state_next = HRD;
                end else if (bus.in_valid_i) begin
                    word_next  = bus.in_addr_i[AW-1:2];
                    data_next  = bus.in_data_i;
                    first_next = bus.in_first_i;
                    state_next = bus.in_first_i ? WR : RD;
                end
            end

            RD: begin
                ram_en     = 1'b1;
                ram_we     = 1'b1;
                op_addr    = {word_reg, 2'b00};
                state_next = ADD;
            end

            // SRAM data from the RD cycle is valid here
            ADD: begin
                sum_next   = add_result;
                state_next = WR;
            end

            WR: begin
                ram_en     = 1'b1;
                ram_we     = 1'b0;
                op_addr    = {word_reg, 2'b00};
                ram_wdata  = first_reg ? data_reg : sum_reg;
                state_next = IDLE;
            end

            HRD: begin
                ram_en     = 1'b1;
                ram_we     = 1'b1;
                op_addr    = {word_reg, 2'b00};
                state_next = HCAP;
            end

            HCAP: begin
                rd_data_next  = bus.ram_rdata_i;
                rd_valid_next = 1'b1;
                state_next    = IDLE;
            end

            CLR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b0;
                op_addr   = clr_addr;
                ram_wdata = '0;
                cnt_next  = cnt_reg + CW'(1);
                if (cnt_reg == CW'(DEPTH - 1)) begin
                    clr_done_next = 1'b1;
                    state_next    = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            word_reg     <= '0;
            data_reg     <= '0;
            first_reg    <= 1'b0;
            sum_reg      <= '0;
            cnt_reg      <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
            clr_done_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            word_reg     <= word_next;
            data_reg     <= data_next;
            first_reg    <= first_next;
            sum_reg      <= sum_next;
            cnt_reg      <= cnt_next;
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_valid_next;
            clr_done_reg <= clr_done_next;
            busy_reg     <= (state_next != IDLE);
        end
    end

    assign bus.in_ready_o   = in_ready;
    assign bus.rd_ack_o     = rd_ack;
    assign bus.rd_valid_o   = rd_valid_reg;
    assign bus.rd_data_o    = rd_data_reg;
    assign bus.clr_done_o   = clr_done_reg;
    assign bus.busy_o       = busy_reg;
    assign bus.ram_en_o     = ram_en;
    assign bus.ram_we_o     = ram_we;
    assign bus.ram_w_addr_o = op_addr;
    assign bus.ram_r_addr_o = op_addr;
    assign bus.ram_wdata_o  = ram_wdata;

endmodule

// File: doc/acc_rmw_ctrl.md
Name: acc_rmw_ctrl

Overview:
Read-modify-write accumulation controller placed directly upstream of the 2048x32 accumulator SRAM (acc_ram).
- Accepts signed 32-bit partial sums from the MAC array and adds each one into the addressed accumulator word, or overwrites that word on the first pass.
- Arbitrates host readout and a full-array clear onto the same single SRAM port.
- Serial operation: one operation in flight, so no address hazards exist.

Parameters:
AW, 13, byte address width; word index = addr[AW-1:2].
DW, 32, data width.
DEPTH, 2048, number of SRAM words.
SATURATE, 0, 1 = signed saturating add; 0 = wrap modulo 2^32.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
clear_i  in  1  request zero-fill of all DEPTH words (level; sampled in IDLE)
clr_done_o  out  1  one-cycle pulse when clear completes
in_valid_i  in  1  partial sum valid
in_ready_o  out  1  partial sum accepted when in_valid_i & in_ready_o
in_addr_i  in  AW  byte address; bits [1:0] ignored
in_data_i  in  DW  signed partial sum
in_first_i  in  1  1 = write in_data_i, no read
rd_req_i  in  1  host read request
rd_addr_i  in  AW  host byte address
rd_ack_o  out  1  host request accepted this cycle
rd_valid_o  out  1  rd_data_o valid, one-cycle pulse
rd_data_o  out  DW  host read data
busy_o  out  1  state != IDLE
ram_en_o  out  1  SRAM enable (acc_ram en_i)
ram_we_o  out  1  0 = write, 1 = read (acc_ram we_i)
ram_w_addr_o  out  AW  write address
ram_r_addr_o  out  AW  read address
ram_wdata_o  out  DW  write data
ram_rdata_i  in  DW  SRAM read data, valid the cycle after a read cycle

Behaviour:
- Reset: async on rst high. State=IDLE; all ram_* outputs 0 except ram_we_o=1; rd_valid_o=0; rd_data_o=0; clr_done_o=0; busy_o=0; internal registers 0. An operation in progress is abandoned; any write not already clocked is lost.
- SRAM address rule: ram_w_addr_o = ram_r_addr_o = current operation address, with bits [1:0]=0. Both are 0 when ram_en_o=0.
- IDLE: ram_en_o=0. Priority is clear_i > rd_req_i > in_valid_i.
  - in_ready_o = ~clear_i & ~rd_req_i (combinational, IDLE only).
  - rd_ack_o = ~clear_i & rd_req_i (combinational, IDLE only).
  - Clear request: cnt<=0 -> CLR.
  - Host request: latch rd_addr_i -> HRD.
  - Accepted partial sum: latch addr, data, first. first=1 -> WR; first=0 -> RD.
- RD: en=1, we=1 -> ADD.
- ADD: sum_q <= ram_rdata_i + data_q.
  - SATURATE=1: positive overflow gives 0x7FFFFFFF; negative overflow gives 0x80000000.
  - -> WR.
- WR: en=1, we=0, wdata = first_q ? data_q : sum_q -> IDLE.
- HRD: en=1, we=1 -> HCAP.
- HCAP: rd_data_o <= ram_rdata_i; rd_valid_o <= 1 (visible next cycle, one cycle only) -> IDLE. rd_data_o holds its value until the next HCAP.
- CLR: en=1, we=0, wdata=0, addr={cnt,2'b00}.
  - cnt increments each cycle.
  - At cnt=DEPTH-1 the write is issued, then -> IDLE and clr_done_o pulses in the next cycle.
  - Clear takes DEPTH cycles; clear_i is ignored while in CLR.
- Timing, with acceptance at cycle T:
  - Accumulate: RD T+1, ADD T+2, WR T+3, in_ready_o possible at T+4.
  - First write: WR T+1, ready at T+2.
  - Host read: ack T, HRD T+1, HCAP T+2, rd_valid_o at T+3.
- busy_o is registered from the state (state != IDLE). Handshake inputs are ignored outside IDLE.

Decomposition:
- Package acc_pkg holds:
  - state encoding IDLE, RD, ADD, WR, HRD, HCAP, CLR;
  - AW/DW/DEPTH defaults;
  - the constants SAT_MAX=0x7FFFFFFF and SAT_MIN=0x80000000.
- One sub-module, acc_sat_add: combinational DW-bit signed adder with a SATURATE parameter. It is unit-tested separately.

Test Plan:
- First then accumulate: in_first=1 addr 0x10 data 5, then in_first=0 addr 0x10 data 7, then host read 0x10 -> rd_data_o=12; ram_we_o=0 exactly at T+1 (first) and T+3 (accumulate).
- Negative and wrap, SATURATE=0: first 0x7FFFFFFF, then add 1 -> 0x80000000. Repeat with SATURATE=1 -> 0x7FFFFFFF; first 0x80000000, add -1 -> 0x80000000.
- Arbitration: clear_i, rd_req_i and in_valid_i all asserted in IDLE -> CLR entered; rd_ack_o=0 and in_ready_o=0 throughout; after 2048 cycles clr_done_o pulses once; then rd_ack_o precedes in_ready_o.
- Clear contents: write 0xDEADBEEF at 0x1FFC and 0x0000, run a clear, read both -> 0; clear length is exactly 2048 write cycles.
- Reset mid-op: assert rst during ADD -> outputs go to reset values immediately; a later read shows the pre-op value unchanged.
- Address bits [1:0]: accumulate at 0x13 -> the write targets 0x10; read 0x11 returns the same word.
